// File: rtl/mem_bus_arbiter.sv
// Arbiter that shares one req/ack memory bus between the instruction fetch port and the data port.
// Each requester gets one registered transaction at a time. A timeout aborts a transaction that is never acked.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DATA_BURST_MAX = 4,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  input  logic                  d_re,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]            d_byte_slct,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  hold_pipe,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_byte_slct,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  bus_err
);

  // With TIMEOUT=0 the wait counter still needs one bit. It is never compared against anything.
  localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned BW = $clog2(DATA_BURST_MAX + 1);
  localparam logic [WW-1:0] WAIT_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;
  localparam logic [BW-1:0] BURST_MAX = BW'(DATA_BURST_MAX);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    INST
  } state_e;

  state_e                  state_q;
  logic                    bus_req_q;
  logic                    bus_we_q;
  logic [ADDR_WIDTH-1:0]   bus_addr_q;
  logic [DATA_WIDTH-1:0]   bus_wdata_q;
  logic [3:0]              bus_slct_q;
  logic                    bus_err_q;
  logic                    i_ready_q;
  logic                    d_ready_q;
  logic [DATA_WIDTH-1:0]   i_rdata_q;
  logic [DATA_WIDTH-1:0]   d_rdata_q;
  logic [WW-1:0]           wait_cnt_q;
  logic [BW-1:0]           burst_cnt_q;

  logic                    d_elig;
  logic                    i_elig;
  logic                    data_win;
  logic                    inst_win;
  logic                    timeout_hit;
  logic [WW-1:0]           wait_cnt_d;
  logic [BW-1:0]           burst_cnt_d;

  always_comb begin
    // A port whose ready pulse is high this cycle has already been served.
    d_elig      = (d_re | d_we) & ~d_ready_q;
    i_elig      = i_req & ~i_ready_q;
    data_win    = d_elig & ~(i_elig & (burst_cnt_q == BURST_MAX));
    inst_win    = i_elig & ~data_win;
    timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST);
    wait_cnt_d  = wait_cnt_q + WW'(1);
    burst_cnt_d = '0;
    if (data_win && i_elig) begin
      burst_cnt_d = (burst_cnt_q == BURST_MAX) ? BURST_MAX : burst_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_slct_q  <= '0;
      bus_err_q   <= 1'b0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      bus_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (data_win) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= d_we;
            bus_addr_q  <= d_addr;
            bus_wdata_q <= d_wdata;
            bus_slct_q  <= d_byte_slct;
            wait_cnt_q  <= '0;
            burst_cnt_q <= burst_cnt_d;
            state_q     <= DATA;
          end else if (inst_win) begin
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= i_addr;
            bus_wdata_q <= '0;
            bus_slct_q  <= 4'hF;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
            state_q     <= INST;
          end
        end
        DATA, INST: begin
          // An ack in the same cycle as timeout expiry counts as a normal completion.
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            state_q   <= IDLE;
            if (state_q == DATA) begin
              d_rdata_q <= bus_rdata;
              d_ready_q <= 1'b1;
            end else begin
              i_rdata_q <= bus_rdata;
              i_ready_q <= 1'b1;
            end
          end else begin
            wait_cnt_q <= wait_cnt_d;
            if (timeout_hit) begin
              bus_req_q <= 1'b0;
              bus_err_q <= 1'b1;
              state_q   <= IDLE;
              if (state_q == DATA) begin
                d_rdata_q <= '0;
                d_ready_q <= 1'b1;
              end else begin
                i_rdata_q <= '0;
                i_ready_q <= 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hold_pipe     = i_elig | d_elig;
  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_byte_slct = bus_slct_q;
  assign bus_err       = bus_err_q;
  assign i_ready       = i_ready_q;
  assign d_ready       = d_ready_q;
  assign i_rdata       = i_rdata_q;
  assign d_rdata       = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_mem_bus_arbiter;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned BMAX = 4;
  localparam int unsigned TMO  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_re;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [3:0]    d_byte_slct;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          hold_pipe;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [3:0]    bus_byte_slct;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;
  logic          bus_err;

  int checks = 0;
  int errors = 0;

  // Reference model state: one outstanding transaction at most.
  logic          m_busy;
  logic          m_is_data;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_slct;
  logic          m_err;
  logic          m_ir;
  logic          m_dr;
  logic [DW-1:0] m_ird;
  logic [DW-1:0] m_drd;
  int            m_waits;
  int            m_burst;

  mem_bus_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DATA_BURST_MAX(BMAX),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_slct(d_byte_slct), .d_rdata(d_rdata), .d_ready(d_ready),
    .hold_pipe(hold_pipe),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_byte_slct(bus_byte_slct), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = '0;
    d_re = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_byte_slct = '0;
    bus_ack = 1'b0; bus_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_is_data = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    m_slct = '0; m_err = 1'b0; m_ir = 1'b0; m_dr = 1'b0; m_ird = '0; m_drd = '0;
    m_waits = 0; m_burst = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic d_want;
    logic i_want;
    d_want = (d_re || d_we) && !m_dr;
    i_want = i_req && !m_ir;
    m_ir = 1'b0; m_dr = 1'b0; m_err = 1'b0;
    if (!m_busy) begin
      if (d_want && !(i_want && m_burst == int'(BMAX))) begin
        m_busy = 1'b1; m_is_data = 1'b1; m_we = d_we; m_addr = d_addr;
        m_wdata = d_wdata; m_slct = d_byte_slct; m_waits = 0;
        m_burst = i_want ? ((m_burst + 1 > int'(BMAX)) ? int'(BMAX) : m_burst + 1) : 0;
      end else if (i_want) begin
        m_busy = 1'b1; m_is_data = 1'b0; m_we = 1'b0; m_addr = i_addr;
        m_wdata = '0; m_slct = 4'hF; m_waits = 0; m_burst = 0;
      end
    end else if (bus_ack) begin
      m_busy = 1'b0;
      if (m_is_data) begin m_dr = 1'b1; m_drd = bus_rdata; end
      else begin m_ir = 1'b1; m_ird = bus_rdata; end
    end else begin
      m_waits++;
      if (TMO != 0 && m_waits == int'(TMO)) begin
        m_busy = 1'b0; m_err = 1'b1;
        if (m_is_data) begin m_dr = 1'b1; m_drd = '0; end
        else begin m_ir = 1'b1; m_ird = '0; end
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req got %0h want 0", bus_req); end
    checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL rst_bus_we got %0h want 0", bus_we); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err got %0h want 0", bus_err); end
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL rst_i_ready got %0h want 0", i_ready); end
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL rst_d_ready got %0h want 0", d_ready); end
    checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL rst_bus_addr got %0h want 0", bus_addr); end
    checks++; if (i_rdata !== 32'h0) begin errors++; $display("FAIL rst_i_rdata got %0h want 0", i_rdata); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL rst_d_rdata got %0h want 0", d_rdata); end
    checks++; if (hold_pipe !== 1'b0) begin errors++; $display("FAIL rst_hold got %0h want 0", hold_pipe); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    do_reset();
    i_req = 1'b1; i_addr = 32'h100;
    #1;
    checks++; if (hold_pipe !== 1'b1) begin errors++; $display("FAIL fetch_hold0 got %0h want 1", hold_pipe); end
    tick();
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL fetch_req got %0h want 1", bus_req); end
    checks++; if (bus_addr !== 32'h100) begin errors++; $display("FAIL fetch_addr got %0h want 100", bus_addr); end
    checks++; if (bus_byte_slct !== 4'hF) begin errors++; $display("FAIL fetch_slct got %0h want f", bus_byte_slct); end
    checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL fetch_we got %0h want 0", bus_we); end
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL fetch_early_ready got %0h want 0", i_ready); end
    bus_ack = 1'b1; bus_rdata = 32'h2408_0001;
    tick();
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready got %0h want 1", i_ready); end
    checks++; if (i_rdata !== 32'h2408_0001) begin errors++; $display("FAIL fetch_rdata got %0h want 24080001", i_rdata); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL fetch_req_drop got %0h want 0", bus_req); end
    checks++; if (hold_pipe !== 1'b0) begin errors++; $display("FAIL fetch_hold1 got %0h want 0", hold_pipe); end
    i_req = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    tick();
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL fetch_pulse got %0h want 0", i_ready); end
    checks++; if (i_rdata !== 32'h2408_0001) begin errors++; $display("FAIL fetch_hold_rdata got %0h want 24080001", i_rdata); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    i_req = 1'b1; i_addr = 32'h300;
    d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_byte_slct = 4'b0011;
    tick();
    checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1) begin errors++; $display("FAIL sim_data_grant got req=%0h we=%0h want 1 1", bus_req, bus_we); end
    checks++; if (bus_addr !== 32'h200) begin errors++; $display("FAIL sim_data_addr got %0h want 200", bus_addr); end
    checks++; if (bus_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sim_data_wdata got %0h want deadbeef", bus_wdata); end
    checks++; if (bus_byte_slct !== 4'b0011) begin errors++; $display("FAIL sim_data_slct got %0h want 3", bus_byte_slct); end
    checks++; if (hold_pipe !== 1'b1) begin errors++; $display("FAIL sim_hold_a got %0h want 1", hold_pipe); end
    bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    tick();
    checks++; if (d_ready !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL sim_data_done got ready=%0h req=%0h want 1 0", d_ready, bus_req); end
    checks++; if (hold_pipe !== 1'b1) begin errors++; $display("FAIL sim_hold_b got %0h want 1", hold_pipe); end
    d_we = 1'b0; bus_ack = 1'b0;
    tick();
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h300) begin errors++; $display("FAIL sim_inst_grant got req=%0h addr=%0h want 1 300", bus_req, bus_addr); end
    checks++; if (bus_we !== 1'b0 || bus_byte_slct !== 4'hF) begin errors++; $display("FAIL sim_inst_ctl got we=%0h slct=%0h want 0 f", bus_we, bus_byte_slct); end
    checks++; if (hold_pipe !== 1'b1) begin errors++; $display("FAIL sim_hold_c got %0h want 1", hold_pipe); end
    bus_ack = 1'b1; bus_rdata = 32'hABCD_0001;
    tick();
    checks++; if (i_ready !== 1'b1 || i_rdata !== 32'hABCD_0001) begin errors++; $display("FAIL sim_inst_done got ready=%0h rdata=%0h want 1 abcd0001", i_ready, i_rdata); end
    checks++; if (hold_pipe !== 1'b0) begin errors++; $display("FAIL sim_hold_d got %0h want 0", hold_pipe); end
    idle_inputs();
    tick();
  endtask

  task automatic test_starvation();
    bit glog[$];
    bit exp_g[6];
    logic prev_req;
    exp_g = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    prev_req = 1'b0;
    d_re = 1'b1; d_addr = 32'h400; i_req = 1'b1; i_addr = 32'h500;
    for (int n = 0; n < 80 && glog.size() < 6; n++) begin
      tick();
      if (bus_req && !prev_req) glog.push_back(bus_addr == 32'h400);
      prev_req = bus_req;
      bus_ack = bus_req;
      bus_rdata = 32'(n);
      // Fetch steps aside while the data ready pulse is high, so data stays contended.
      i_req = !d_ready;
    end
    checks++;
    if (glog.size() < 6) begin
      errors++; $display("FAIL starve_count got %0d want 6", glog.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (glog[k] !== exp_g[k]) begin errors++; $display("FAIL starve_grant%0d got data=%0d want data=%0d", k, glog[k], exp_g[k]); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_wait_states();
    do_reset();
    d_re = 1'b1; d_addr = 32'h600; d_wdata = 32'h1122_3344; d_byte_slct = 4'hC;
    tick();
    d_addr = 32'hFFFF; d_wdata = 32'h0; d_byte_slct = 4'h1;
    for (int k = 1; k <= 6; k++) begin
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL ws_req%0d got %0h want 1", k, bus_req); end
      checks++; if (bus_addr !== 32'h600 || bus_wdata !== 32'h1122_3344) begin errors++; $display("FAIL ws_stable%0d got %0h/%0h want 600/11223344", k, bus_addr, bus_wdata); end
      checks++; if (d_ready !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL ws_early%0d got ready=%0h err=%0h want 0 0", k, d_ready, bus_err); end
      if (k == 6) begin bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D; end
      tick();
    end
    checks++; if (d_ready !== 1'b1 || d_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL ws_done got ready=%0h rdata=%0h want 1 cafef00d", d_ready, d_rdata); end
    checks++; if (bus_req !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL ws_end got req=%0h err=%0h want 0 0", bus_req, bus_err); end
    d_re = 1'b0; bus_ack = 1'b0;
    tick();
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL ws_single got %0h want 0", d_ready); end
  endtask

  task automatic test_timeout();
    do_reset();
    d_re = 1'b1; d_addr = 32'h700;
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_0BAD;
    // Preload d_rdata with a nonzero value so the abort clearing it is visible.
    tick();
    tick();
    d_re = 1'b0; bus_ack = 1'b0;
    tick();
    d_re = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      checks++; if (bus_req !== 1'b1 || bus_err !== 1'b0) begin errors++; $display("FAIL tmo_wait%0d got req=%0h err=%0h want 1 0", k, bus_req, bus_err); end
      tick();
    end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL tmo_drop got %0h want 0", bus_req); end
    checks++; if (bus_err !== 1'b1 || d_ready !== 1'b1) begin errors++; $display("FAIL tmo_pulse got err=%0h ready=%0h want 1 1", bus_err, d_ready); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL tmo_rdata got %0h want 0", d_rdata); end
    d_re = 1'b0;
    tick();
    checks++; if (bus_err !== 1'b0 || d_ready !== 1'b0) begin errors++; $display("FAIL tmo_pulse_end got err=%0h ready=%0h want 0 0", bus_err, d_ready); end
    d_we = 1'b1; d_addr = 32'h710; d_wdata = 32'h55;
    tick();
    checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h710) begin errors++; $display("FAIL tmo_next_grant got req=%0h we=%0h addr=%0h want 1 1 710", bus_req, bus_we, bus_addr); end
    bus_ack = 1'b1;
    tick();
    checks++; if (d_ready !== 1'b1 || bus_err !== 1'b0) begin errors++; $display("FAIL tmo_next_done got ready=%0h err=%0h want 1 0", d_ready, bus_err); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_re = 1'b1; d_addr = 32'h800;
    tick();
    tick();
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rm_busy got %0h want 1", bus_req); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b0 || bus_addr !== 32'h0) begin errors++; $display("FAIL rm_async got req=%0h addr=%0h want 0 0", bus_req, bus_addr); end
    bus_ack = 1'b1;
    tick();
    checks++; if (d_ready !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL rm_no_ready got ready=%0h err=%0h want 0 0", d_ready, bus_err); end
    bus_ack = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h800) begin errors++; $display("FAIL rm_regrant got req=%0h addr=%0h want 1 800", bus_req, bus_addr); end
    bus_ack = 1'b1; bus_rdata = 32'h7777;
    tick();
    checks++; if (d_ready !== 1'b1 || d_rdata !== 32'h7777) begin errors++; $display("FAIL rm_done got ready=%0h rdata=%0h want 1 7777", d_ready, d_rdata); end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    int unsigned sel;
    logic exp_hold;
    do_reset();
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 2);
      d_re = (sel == 1);
      d_we = (sel == 2);
      i_req = 1'($urandom_range(0, 1));
      i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
      d_byte_slct = 4'($urandom);
      bus_ack = ($urandom_range(0, 3) == 0);
      bus_rdata = $urandom;
      #1;
      exp_hold = (i_req && !m_ir) || ((d_re || d_we) && !m_dr);
      checks++; if (hold_pipe !== exp_hold) begin errors++; $display("FAIL rnd_hold n=%0d got %0h want %0h", n, hold_pipe, exp_hold); end
      model_step();
      tick();
      checks++; if (bus_req !== m_busy) begin errors++; $display("FAIL rnd_req n=%0d got %0h want %0h", n, bus_req, m_busy); end
      checks++; if (bus_we !== m_we) begin errors++; $display("FAIL rnd_we n=%0d got %0h want %0h", n, bus_we, m_we); end
      checks++; if (bus_addr !== m_addr) begin errors++; $display("FAIL rnd_addr n=%0d got %0h want %0h", n, bus_addr, m_addr); end
      checks++; if (bus_wdata !== m_wdata) begin errors++; $display("FAIL rnd_wdata n=%0d got %0h want %0h", n, bus_wdata, m_wdata); end
      checks++; if (bus_byte_slct !== m_slct) begin errors++; $display("FAIL rnd_slct n=%0d got %0h want %0h", n, bus_byte_slct, m_slct); end
      checks++; if (bus_err !== m_err) begin errors++; $display("FAIL rnd_err n=%0d got %0h want %0h", n, bus_err, m_err); end
      checks++; if (i_ready !== m_ir) begin errors++; $display("FAIL rnd_i_ready n=%0d got %0h want %0h", n, i_ready, m_ir); end
      checks++; if (d_ready !== m_dr) begin errors++; $display("FAIL rnd_d_ready n=%0d got %0h want %0h", n, d_ready, m_dr); end
      checks++; if (i_rdata !== m_ird) begin errors++; $display("FAIL rnd_i_rdata n=%0d got %0h want %0h", n, i_rdata, m_ird); end
      checks++; if (d_rdata !== m_drd) begin errors++; $display("FAIL rnd_d_rdata n=%0d got %0h want %0h", n, d_rdata, m_drd); end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
